datapath: RTL and testbench

//  - Next-generation engine for an 8x8 Conway Game of Life board.
//  - Pure combinational next_state from state, plus registered status outputs (population, stable).
//  - Sits between the board-state register (owned by the controller) and the display/scan logic.
//  - The controller feeds next_state back into state each generation.

---
 rtl/life_pkg.sv | 10 +
 rtl/life_cell.sv | 10 +
 rtl/datapath.sv | 49 ++++
 tb/tb_datapath.sv | 111 +++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: board geometry, board type and cell index mapping for the life engine
package life_pkg;
  localparam int GRID_W = 8;
  localparam int GRID_H = 8;
  localparam int CELLS = 64;
  typedef logic [CELLS-1:0] board_t;
  function automatic logic [5:0] cell_idx(input int r, input int c);
    return 6'(CELLS - 1 - (GRID_W * r + c));
  endfunction
endpackage

// File: rtl/life_cell.sv
// life_cell: counts eight neighbours and applies the B3/S23 rule to one cell
module life_cell (
  input  logic       alive,
  input  logic [7:0] nbrs,
  output logic       next
);
  logic [3:0] cnt;
  assign cnt = 4'($countones(nbrs));
  assign next = (cnt == 4'd3) | (alive & (cnt == 4'd2));
endmodule

// File: rtl/datapath.sv
// datapath: combinational 8x8 life generation plus registered population/stable status.
// Define TORUS_WRAP_EN to wrap rows and columns; otherwise off-board cells are dead.
module datapath
  import life_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  board_t     state,
  output board_t     next_state,
  output logic [6:0] population,
  output logic       stable
);
  // 10x10 halo around the board so every cell sees a uniform 3x3 window
  logic [GRID_H+1:0][GRID_W+1:0] pad;
  logic [6:0] pop;
  for (genvar r = 0; r < GRID_H + 2; r++) begin : g_pad_r
    for (genvar c = 0; c < GRID_W + 2; c++) begin : g_pad_c
`ifdef TORUS_WRAP_EN
      assign pad[r][c] = state[cell_idx((r + GRID_H - 1) % GRID_H, (c + GRID_W - 1) % GRID_W)];
`else
      if (r > 0 && r <= GRID_H && c > 0 && c <= GRID_W) begin : g_in
        assign pad[r][c] = state[cell_idx(r - 1, c - 1)];
      end else begin : g_out
        assign pad[r][c] = 1'b0;
      end
`endif
    end
  end
  for (genvar r = 0; r < GRID_H; r++) begin : g_row
    for (genvar c = 0; c < GRID_W; c++) begin : g_col
      life_cell u_cell (
        .alive(state[cell_idx(r, c)]),
        .nbrs ({pad[r][c], pad[r][c+1], pad[r][c+2], pad[r+1][c],
                pad[r+1][c+2], pad[r+2][c], pad[r+2][c+1], pad[r+2][c+2]}),
        .next (next_state[cell_idx(r, c)])
      );
    end
  end
  assign pop = 7'($countones(next_state));
  always_ff @(posedge clk) begin
    if (reset) begin
      population <= '0;
      stable <= 1'b0;
    end else begin
      population <= pop;
      stable <= (next_state == state);
    end
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: scoreboard bench for datapath with an independent loop-based life model
module tb_datapath;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] state = '0;
  logic [63:0] next_state;
  logic [6:0] population;
  logic stable;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  localparam logic [63:0] VB = (64'd1 << 62) | (64'd1 << 54) | (64'd1 << 46);
  localparam logic [63:0] HB = (64'd1 << 55) | (64'd1 << 54) | (64'd1 << 53);
  localparam logic [63:0] LT = (64'd1 << 18) | (64'd1 << 17) | (64'd1 << 10);
  localparam logic [63:0] BLK = LT | (64'd1 << 9);
  localparam logic [63:0] CRN = (64'd1 << 63) | (64'd1 << 55) | (64'd1 << 47);
`ifdef TORUS_WRAP_EN
  localparam logic [63:0] CRN_NX = (64'd1 << 55) | (64'd1 << 54) | (64'd1 << 48);
`else
  localparam logic [63:0] CRN_NX = (64'd1 << 55) | (64'd1 << 54);
`endif

  datapath dut (
    .clk(clk), .reset(reset), .state(state),
    .next_state(next_state), .population(population), .stable(stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] s);
    logic [63:0] n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
`ifdef TORUS_WRAP_EN
            rr = (rr + 8) % 8;
            cc = (cc + 8) % 8;
`else
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
            cnt += int'(s[63 - (8 * rr + cc)]);
          end
        n[63 - (8 * r + c)] = (cnt == 3) || (s[63 - (8 * r + c)] && cnt == 2);
      end
    return n;
  endfunction

  task automatic apply(input logic [63:0] s, input logic [63:0] exp_ns);
    logic [7:0] e;
    state = s;
    #1;
    check("next_state", next_state, exp_ns);
    exp_q.push_back({exp_ns == s, 7'($countones(exp_ns))});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("population", 64'(population), 64'(e[6:0]));
    check("stable", 64'(stable), 64'(e[7]));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_population", 64'(population), 64'd0);
    check("rst_stable", 64'(stable), 64'd0);
    reset = 1'b0;
    apply(VB | LT, HB | BLK);
    apply(HB | BLK, VB | BLK);
    apply(VB | BLK, HB | BLK);
    apply(HB | BLK, VB | BLK);
    apply(BLK, BLK);
    apply('0, '0);
    apply(CRN, CRN_NX);
    for (int i = 0; i < 24; i++) begin
      logic [63:0] s = {$urandom, $urandom};
      if (i % 3 == 0) s &= {$urandom, $urandom};
      apply(s, model(s));
    end
    apply(VB | LT, HB | BLK);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_population", 64'(population), 64'd0);
    check("mid_rst_stable", 64'(stable), 64'd0);
    check("rst_next_state", next_state, HB | BLK);
    state = BLK;
    @(posedge clk);
    #1;
    check("rst_stable_blk", 64'(stable), 64'd0);
    check("rst_next_state_blk", next_state, BLK);
    reset = 1'b0;
    apply(BLK, BLK);
    apply(VB | LT, HB | BLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
